// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues one outstanding read at a time
// through the shared bus, and buffers {instr, pc} pairs for the decoder.
module instr_fetch_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8,
  parameter int AW    = 16,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_gnt,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_rvalid,
  output logic            instr_valid,
  output logic [DW-1:0]   instr,
  output logic [PC_W-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic             discard_q, discard_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DW-1:0]    instr_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem [DEPTH];
  logic             push, pop, room, room_next;

  // A redirect kills both the landing response and any same-cycle pop.
  assign push        = (state_q == WAIT) && mem_rvalid && !discard_q && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;
  assign room        = count_q < DEPTH_C;
  assign room_next   = count_d < DEPTH_C;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? instr_mem[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : '0;
  assign mem_addr    = AW'(fetch_pc_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    mem_req    = 1'b0;
    if (redirect) fetch_pc_d = redirect_pc;
    case (state_q)
      IDLE: begin
        if (fetch_en && room && !redirect) state_d = REQ;
      end
      REQ: begin
        mem_req = !redirect;
        if (!redirect) begin
          if (mem_gnt) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 1'b1;
            state_d    = WAIT;
          end else if (!fetch_en) begin
            state_d = IDLE;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          discard_d = 1'b0;
          state_d   = (fetch_en && room_next) ? REQ : IDLE;
        end else if (redirect) begin
          // The read already left; mark its response stale rather than cancel it.
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= mem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage feeding the decode/execute sequencer.
- Owns the fetch PC and issues instruction reads to unified memory through the shared address-bus arbitration; data accesses have priority and are resolved by the grant.
- Buffers returned instructions with their PC in a small FIFO and presents them to the decoder over a valid/ready handshake.
- Accepts redirects (branch/PC load) that flush buffered and in-flight instructions.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
PC_W, 8, program counter width
AW, 16, memory address width (PC zero-extended)
DW, 32, instruction width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
fetch_en  in  1  enable fetching (low during program load)
mem_req  out  1  instruction read request
mem_addr  out  AW  read address = zero-extended fetch PC
mem_gnt  in  1  request accepted this cycle (qualified by mem_req)
mem_rdata  in  DW  read data
mem_rvalid  in  1  mem_rdata valid; arrives >=1 cycle after grant
instr_valid  out  1  FIFO head valid
instr  out  DW  FIFO head instruction
instr_pc  out  PC_W  PC of head instruction
instr_ready  in  1  decoder consumes head when instr_valid=1
redirect  in  1  one-cycle redirect strobe
redirect_pc  in  PC_W  new fetch PC

Behaviour:
- Reset (rst=0, async): state IDLE; fetch_pc=0; FIFO empty (count=0, pointers 0); discard=0; req_pc=0; mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0.
- At most one outstanding read. room = (count < DEPTH); an outstanding read always has a reserved slot, so a push never overflows.
- FSM:
  - IDLE: mem_req=0. Go to REQ when fetch_en && room && !redirect.
  - REQ: mem_req=1 unless redirect this cycle; mem_addr={0,fetch_pc}, held stable while ungranted.
    - mem_gnt: req_pc<=fetch_pc; fetch_pc<=fetch_pc+1 (mod 2^PC_W); go to WAIT.
    - fetch_en=0 before grant: withdraw, go to IDLE.
  - WAIT: mem_req=0. On mem_rvalid:
    - If discard=0, push {mem_rdata, req_pc}.
    - Clear discard.
    - Go to REQ if fetch_en && count_next<DEPTH, else IDLE.
  - fetch_en falling in WAIT does not cancel; the response is still pushed.
- Throughput: with a 1-cycle memory, one instruction per 2 cycles.
- Output: instr_valid=(count!=0); instr/instr_pc = head entry, forced 0 when empty. Pop on instr_valid && instr_ready. Push and pop in the same cycle: count unchanged, both pointers advance.
- Redirect (highest priority, same-cycle):
  - FIFO flushed (count<=0, pointers<=0); instr_valid=0 from the next cycle; a pop in the redirect cycle is ignored.
  - fetch_pc<=redirect_pc.
  - mem_req forced 0 in the redirect cycle, so no grant is accepted.
  - In WAIT without mem_rvalid: discard<=1; the stale response is dropped later. In WAIT with mem_rvalid in the same cycle: the response is dropped and the FSM proceeds to REQ/IDLE as normal.
  - In REQ: stay in REQ, new address next cycle. In IDLE: stay in IDLE.
- mem_rvalid outside WAIT is ignored. mem_gnt with mem_req=0 is ignored.
- PC wrap: 2^PC_W-1 increments to 0, no flag.

Test Plan:
- Reset mid-WAIT (rst low while read outstanding, FIFO holding 2) -> mem_req=0, instr_valid=0, instr=0, instr_pc=0 immediately. After release, the late mem_rvalid is ignored and the first request is addr 0x0000.
- Streaming: fetch_en=1, gnt=1, rvalid 1 cycle after grant, mem[k]=0xA0000000+k, ready=1 -> instr_pc 0,1,2,3 with instr 0xA0000000..03, one every 2 cycles, first valid 3 cycles after fetch_en.
- Full: ready=0, DEPTH=4 -> exactly 4 grants (addr 0..3), then mem_req stays 0 and head is pc 0. One-cycle ready pulse -> head becomes pc 1 and the next request has addr 0x0004.
- Redirect in WAIT, redirect_pc=0x20, FIFO holding 2 -> instr_valid=0 the next cycle. The in-flight response (pc 2) is never presented; next mem_addr=0x0020, first instr_pc=0x20.
- Grant stall: mem_gnt=0 for 5 cycles -> mem_req=1 and mem_addr constant all 5 cycles; fetch_pc advances once, only on grant.
- Wrap: redirect_pc=0xFF -> requests addr 0x00FF then 0x0000; instr_pc 0xFF then 0x00.
